// File: rtl/ula_pkg.sv
// rtl/ula_pkg.sv - shared op codes, FSM states and flag bundle for ula_seq
package ula_pkg;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b010,
    OP_SUB = 3'b011,
    OP_XOR = 3'b100,
    OP_SLT = 3'b101,
    OP_SHL = 3'b110,
    OP_MUL = 3'b111
  } ula_op_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MUL_RUN = 2'd1,
    ST_HOLD    = 2'd2
  } ula_state_t;

  typedef struct packed {
    logic v;
    logic c;
    logic z;
    logic n;
  } ula_flags_t;

endpackage

// File: rtl/ula_seq_if.sv
// rtl/ula_seq_if.sv - operand/result handshake bundle between the datapath and ula_seq
interface ula_seq_if #(
  parameter int W = 8
);

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [2:0]   F;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] RESULT;
  logic         FLAG_V;
  logic         FLAG_C;
  logic         FLAG_Z;
  logic         FLAG_N;

  modport master (
    output in_valid, A, B, F, out_ready,
    input  in_ready, out_valid, RESULT, FLAG_V, FLAG_C, FLAG_Z, FLAG_N
  );

  modport slave (
    input  in_valid, A, B, F, out_ready,
    output in_ready, out_valid, RESULT, FLAG_V, FLAG_C, FLAG_Z, FLAG_N
  );

endinterface

// File: rtl/ula_mul_iter.sv
// rtl/ula_mul_iter.sv - unsigned W x W shift-add multiplier, one partial product per cycle
module ula_mul_iter #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start_i,
  input  logic [W-1:0]   mcand_i,
  input  logic [W-1:0]   mplier_i,
  output logic           done_o,
  output logic [2*W-1:0] prod_o
);

  localparam int CW = $clog2(W);

  logic [2*W-1:0] acc_q;
  logic [2*W-1:0] mcand_q;
  logic [W-1:0]   mplier_q;
  logic [CW-1:0]  cnt_q;
  logic           done_q;
  logic [2*W-1:0] addend_d;

  assign addend_d = mplier_q[0] ? mcand_q : '0;

  // The start cycle already folds in multiplier bit 0, so W-1 further steps
  // leave the product registered one cycle before the owner's W-th run cycle ends.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        acc_q    <= mplier_i[0] ? {{W{1'b0}}, mcand_i} : '0;
        mcand_q  <= {{(W-1){1'b0}}, mcand_i, 1'b0};
        mplier_q <= mplier_i >> 1;
        cnt_q    <= CW'(W-1);
      end else if (cnt_q != '0) begin
        acc_q    <= acc_q + addend_d;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q - CW'(1);
        done_q   <= (cnt_q == CW'(1));
      end
    end
  end

  assign done_o = done_q;
  assign prod_o = acc_q;

endmodule

// File: rtl/ula_seq.sv
// rtl/ula_seq.sv - registered W-bit ALU with valid/ready handshake, full flag set and iterative MUL
module ula_seq
  import ula_pkg::*;
#(
  parameter int W = 8
) (
  input  logic      clk,
  input  logic      reset,
  ula_seq_if.slave  bus
);

  localparam int SHW = $clog2(W);
  localparam logic [2*W-1:0] ONE2W = 1;

  ula_state_t     state_q;
  logic [W-1:0]   result_q;
  ula_flags_t     flags_q;
  logic           out_valid_q;
  logic           in_ready_q;
  logic           neg_q;

  ula_op_t        op_d;
  logic           accept_d;
  logic [W:0]     sum_d;
  logic [W:0]     diff_d;
  logic [W-1:0]   alu_res_d;
  logic           alu_v_d;
  logic           alu_c_d;
  ula_flags_t     alu_flags_d;

  logic [W-1:0]   mag_a_d;
  logic [W-1:0]   mag_b_d;
  logic           mul_start_d;
  logic           mul_done_d;
  logic [2*W-1:0] mul_prod_d;
  logic [2*W-1:0] mul_sprod_d;
  ula_flags_t     mul_flags_d;

  assign op_d     = ula_op_t'(bus.F);
  assign accept_d = in_ready_q && bus.in_valid;
  assign sum_d    = {1'b0, bus.A} + {1'b0, bus.B};
  assign diff_d   = {1'b0, bus.A} - {1'b0, bus.B};

  always_comb begin
    alu_res_d = '0;
    alu_v_d   = 1'b0;
    alu_c_d   = 1'b0;
    case (op_d)
      OP_AND: alu_res_d = bus.A & bus.B;
      OP_OR:  alu_res_d = bus.A | bus.B;
      OP_ADD: begin
        alu_res_d = sum_d[W-1:0];
        alu_c_d   = sum_d[W];
        alu_v_d   = (bus.A[W-1] == bus.B[W-1]) && (sum_d[W-1] != bus.A[W-1]);
      end
      OP_SUB: begin
        alu_res_d = diff_d[W-1:0];
        alu_c_d   = diff_d[W];
        alu_v_d   = (bus.A[W-1] != bus.B[W-1]) && (diff_d[W-1] != bus.A[W-1]);
      end
      OP_XOR: alu_res_d = bus.A ^ bus.B;
      OP_SLT: alu_res_d = W'($signed(bus.A) < $signed(bus.B));
      OP_SHL: alu_res_d = bus.A << bus.B[SHW-1:0];
      default: alu_res_d = '0;
    endcase
    alu_flags_d.v = alu_v_d;
    alu_flags_d.c = alu_c_d;
    alu_flags_d.z = (alu_res_d == '0);
    alu_flags_d.n = alu_res_d[W-1];
  end

  // Multiplier works on magnitudes; the most negative value maps onto itself,
  // which is exactly its unsigned magnitude.
  assign mag_a_d     = bus.A[W-1] ? (~bus.A + W'(1)) : bus.A;
  assign mag_b_d     = bus.B[W-1] ? (~bus.B + W'(1)) : bus.B;
  assign mul_start_d = accept_d && (op_d == OP_MUL);

  ula_mul_iter #(.W(W)) u_mul (
    .clk      (clk),
    .reset    (reset),
    .start_i  (mul_start_d),
    .mcand_i  (mag_a_d),
    .mplier_i (mag_b_d),
    .done_o   (mul_done_d),
    .prod_o   (mul_prod_d)
  );

  // Overflow whenever the upper W+1 bits of the signed product are not a pure sign extension.
  assign mul_sprod_d   = neg_q ? (~mul_prod_d + ONE2W) : mul_prod_d;
  assign mul_flags_d.v = (mul_sprod_d[2*W-1:W-1] != {(W+1){mul_sprod_d[W-1]}});
  assign mul_flags_d.c = 1'b0;
  assign mul_flags_d.z = (mul_sprod_d[W-1:0] == '0);
  assign mul_flags_d.n = mul_sprod_d[W-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      result_q    <= '0;
      flags_q     <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      neg_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_d) begin
            in_ready_q <= 1'b0;
            if (op_d == OP_MUL) begin
              neg_q   <= bus.A[W-1] ^ bus.B[W-1];
              state_q <= ST_MUL_RUN;
            end else begin
              result_q    <= alu_res_d;
              flags_q     <= alu_flags_d;
              out_valid_q <= 1'b1;
              state_q     <= ST_HOLD;
            end
          end
        end
        ST_MUL_RUN: begin
          if (mul_done_d) begin
            result_q    <= mul_sprod_d[W-1:0];
            flags_q     <= mul_flags_d;
            out_valid_q <= 1'b1;
            state_q     <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.RESULT    = result_q;
  assign bus.FLAG_V    = flags_q.v;
  assign bus.FLAG_C    = flags_q.c;
  assign bus.FLAG_Z    = flags_q.z;
  assign bus.FLAG_N    = flags_q.n;

endmodule

// File: doc/ula_seq.md
Name: ula_seq

Overview:
Parametrised, registered successor to the team's 8-bit combinational ULA. Generalises data width, extends the op set from 4 to 8 codes and replaces the single overflow flag with a full flag set (V, C, Z, N). Adds a valid/ready handshake on input and output, plus an iterative multi-cycle signed multiply. Sits between operand registers and the writeback stage of the lab datapath.

Parameters:
W, 8, operand/result width in bits (W >= 4, power of two)
SHW, $clog2(W), shift-amount width (derived, not overridden)

Ports:
clk  in  1  clock, rising-edge
reset  in  1  asynchronous, active-high reset
in_valid  in  1  operands/op presented
in_ready  out  1  block can accept (high only in IDLE)
A  in  W  signed operand A
B  in  W  signed operand B
F  in  3  op code (see Behaviour)
out_valid  out  1  RESULT/flags valid
out_ready  in  1  consumer accepts result
RESULT  out  W  signed result, registered
FLAG_V  out  1  signed overflow
FLAG_C  out  1  carry-out (ADD) / borrow (SUB)
FLAG_Z  out  1  RESULT == 0
FLAG_N  out  1  RESULT[W-1]

Behaviour:
- Op codes: 000 AND, 001 OR, 010 ADD, 011 SUB, 100 XOR, 101 SLT (RESULT=1 if A<B signed, else 0), 110 SHL (A << B[SHW-1:0]), 111 MUL (signed, low W bits).
- Reset (async, any state): state=IDLE, RESULT=0, all flags=0, out_valid=0, in_ready=1 on the first cycle after deassertion; in-flight MUL discarded.
- FSM states IDLE, MUL_RUN, HOLD.
- IDLE: in_ready=1. Accept on in_valid&&in_ready. Non-MUL op -> HOLD next edge with RESULT/flags loaded (latency 1). MUL -> MUL_RUN; operand magnitudes and result sign latched.
- MUL_RUN: one shift-add step per cycle over a 2W-bit accumulator, exactly W cycles. Then the sign is applied and the low W bits plus flags are loaded; -> HOLD. Accept-to-out_valid latency = W+1.
- HOLD: out_valid=1. RESULT and flags stable until out_valid&&out_ready, then -> IDLE. in_ready=0 in MUL_RUN and HOLD; no accept in the cycle HOLD exits.
- Inputs A/B/F are ignored outside the accept cycle; changing them during MUL_RUN has no effect.
- ADD: V = operands same sign and result sign differs; C = unsigned carry-out of bit W-1.
- SUB: V = operands differ in sign and result sign differs from A; C = borrow (A < B unsigned).
- MUL: V=1 iff the true 2W-bit signed product lies outside [-2^(W-1), 2^(W-1)-1]; C=0. -2^(W-1) * 1 is not overflow; -2^(W-1) * -1 is overflow.
- AND/OR/XOR/SLT/SHL: V=0, C=0. SHL fills zeros; shift amount is B[SHW-1:0] only, upper bits of B ignored.
- Z and N are always computed from the final W-bit RESULT, all ops.
- Flags are computed from the true arithmetic, never from the previous registered RESULT.

Decomposition:
- Package ula_pkg: parameter-independent op enum ula_op_t (3-bit, the 8 codes above), FSM enum ula_state_t, packed struct ula_flags_t {v,c,z,n}.
- One sub-module, ula_mul_iter (parametrised by W): start/magnitudes in, W-cycle shift-add, done pulse plus 2W-bit unsigned product out.
- Sign application and V evaluation stay in ula_seq.
- All single-cycle ops are one combinational case block feeding the result/flag registers.

Test Plan:
- W=8, ADD A=100 B=50 -> one cycle after accept RESULT=0x96, V=1 C=0 Z=0 N=1.
- ADD A=0xFF B=0x01 -> RESULT=0x00, V=0 C=1 Z=1 N=0; SUB A=0x80 B=0x01 -> RESULT=0x7F, V=1 C=0 N=0.
- MUL A=-7 B=9 -> out_valid exactly 9 cycles after accept, RESULT=0xC1 (-63), V=0 N=1; MUL 16*16 -> RESULT=0x00, V=1 Z=1; MUL -128*-1 -> V=1.
- Backpressure: out_ready=0 for 5 cycles in HOLD -> RESULT/flags stable, in_ready=0, new in_valid ignored; out_ready=1 -> IDLE, next op accepted the cycle after.
- Reset asserted mid-MUL_RUN, at cycle 4 -> immediately out_valid=0, RESULT=0, flags=0; after release in_ready=1 and SHL A=0x01 B=0x0B gives RESULT=0x08 (B[2:0]=3).
- Sweep: all 8 ops with random A/B x 1000 against a reference model, including A/B in {-128, -1, 0, 127}, and W=16 build regression.
